// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester encoder/decoder.
// Holds the TX and RX state enums, the line-polarity constants and a helper
// that maps a logical bit to its two half-bit line levels.
package manchester_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_GUARD
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA
  } rx_state_t;

  localparam int POL_IEEE   = 0;
  localparam int POL_THOMAS = 1;

  // Returns {first_half, second_half} for one encoded bit.
  // IEEE: 0 -> high,low and 1 -> low,high. Thomas is the inverse.
  function automatic logic [1:0] man_halves(input logic value, input int pol);
    logic [1:0] h;
    h = value ? 2'b01 : 2'b10;
    if (pol == POL_THOMAS) begin
      h = ~h;
    end
    return h;
  endfunction

endpackage

// File: rtl/manchester_rx.sv
// Manchester receive path.
// Synchronises the external line, detects the rising edge that opens a frame,
// samples the decoder input in the middle of every half-bit, checks the start
// bit and each data bit for code violations and assembles the word MSB first.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   rx_in      : asynchronous external Manchester line
//   rx_sync    : synchronised copy of rx_in (the parent picks it or its own TX line)
//   dec_in     : decoder input chosen by the parent
//   rx_data    : last decoded word, held until the next rx_valid
//   rx_valid   : one-cycle pulse when rx_data is updated
//   rx_err     : one-cycle pulse on a code violation
module manchester_rx
  import manchester_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HALF_CYC = 4,
  parameter int POLARITY = POL_IEEE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic              rx_sync,
  input  logic              dec_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);

  localparam int CNT_W = $clog2(HALF_CYC);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_FIRST = CNT_W'(HALF_CYC / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  logic [1:0]        sync;
  logic              prev;
  logic              rise;
  logic              dec_bit;
  logic [DATA_W:0]   shifted;

  rx_state_t         state, state_n;
  logic [CNT_W-1:0]  wait_cnt, wait_n;
  logic              second, second_n;
  logic              first_smp, first_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, err_n;

  // Two-flop synchroniser for the external line, plus a one-cycle delayed
  // copy of the decoder input so a 0 -> 1 transition can be seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], rx_in};
      prev <= dec_in;
    end
  end

  assign rx_sync = sync[1];
  assign rise    = dec_in & ~prev;

  // A pair decodes to 1 exactly when it matches the half pattern of a 1
  // for the configured polarity.
  assign dec_bit = ({first_smp, dec_in} == man_halves(1'b1, POLARITY));
  assign shifted = {shreg, dec_bit};

  // RX state register and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      wait_cnt  <= '0;
      second    <= 1'b0;
      first_smp <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      second    <= second_n;
      first_smp <= first_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      rx_err    <= err_n;
    end
  end

  // RX next-state logic. wait_cnt counts down to the next sample point; the
  // first sample sits half a half-bit after the opening edge and every later
  // one a full half-bit after the previous. 'second' marks the second sample
  // of a pair. Any violation drops the partial word and re-arms edge search.
  always_comb begin
    state_n  = state;
    wait_n   = wait_cnt;
    second_n = second;
    first_n  = first_smp;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    data_n   = rx_data;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rise) begin
          state_n  = RX_START;
          wait_n   = WAIT_FIRST;
          second_n = 1'b0;
        end
      end
      RX_START: begin
        if (wait_cnt != '0) begin
          wait_n = wait_cnt - CNT_W'(1);
        end else begin
          wait_n = CNT_LAST;
          if (!second) begin
            if (dec_in) begin
              second_n = 1'b1;
            end else begin
              err_n   = 1'b1;
              state_n = RX_IDLE;
            end
          end else if (!dec_in) begin
            state_n  = RX_DATA;
            second_n = 1'b0;
            bit_n    = '0;
          end else begin
            err_n   = 1'b1;
            state_n = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (wait_cnt != '0) begin
          wait_n = wait_cnt - CNT_W'(1);
        end else begin
          wait_n = CNT_LAST;
          if (!second) begin
            first_n  = dec_in;
            second_n = 1'b1;
          end else if (first_smp == dec_in) begin
            err_n   = 1'b1;
            state_n = RX_IDLE;
          end else begin
            second_n = 1'b0;
            shreg_n  = shifted[DATA_W-1:0];
            if (bit_cnt == BIT_LAST) begin
              data_n  = shifted[DATA_W-1:0];
              valid_n = 1'b1;
              state_n = RX_IDLE;
            end else begin
              bit_n = bit_cnt + BIT_W'(1);
            end
          end
        end
      end
      default: begin
        state_n = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/manchester_codec.sv
// Parametrised Manchester encoder/decoder.
// The encoder serialises DATA_W-bit words into frames of a start bit, the
// data bits MSB first and a two half-bit low guard. The decoder recovers
// frames from rx_in, or from the encoder's own line when loopback is set.
// Ports:
//   clk, rst_n         : clock and asynchronous active-low reset
//   tx_data, tx_valid  : word to send and its qualifier
//   tx_ready           : high while the encoder is idle and can take a word
//   tx_out             : registered Manchester line, idles low
//   rx_in              : asynchronous external Manchester line
//   loopback           : 1 feeds tx_out straight into the decoder
//   rx_data, rx_valid  : decoded word and its one-cycle strobe
//   rx_err             : one-cycle code-violation pulse
module manchester_codec
  import manchester_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HALF_CYC = 4,
  parameter int POLARITY = POL_IEEE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  input  logic              rx_in,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);

  localparam int CNT_W = $clog2(HALF_CYC);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  // The start bit is the logical value this polarity sends high-first,
  // so it always appears on the line as high then low.
  localparam logic START_BIT = (POLARITY == POL_IEEE) ? 1'b0 : 1'b1;

  tx_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              phase, phase_n;
  logic [BIT_W-1:0]  bit_idx, bit_idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              line, line_n;
  logic [1:0]        start_h, data_h;
  logic              rx_sync;
  logic              dec_in;

  // TX state register. The line level is registered alongside the state so
  // tx_out never passes through combinational logic on its way to the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      phase   <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      line    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      phase   <= phase_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      line    <= line_n;
    end
  end

  // TX next-state logic. cnt runs through one half-bit, phase selects the
  // first or second half of the current bit, and a bit boundary is the end
  // of a second half. The current data bit is always the shift register MSB.
  // The line level is derived from the next-state values so the first high
  // half of the start bit appears on the cycle after acceptance.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    phase_n   = phase;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    line_n    = 1'b0;
    case (state)
      TX_IDLE: begin
        cnt_n   = '0;
        phase_n = 1'b0;
        if (tx_valid) begin
          shreg_n   = tx_data;
          bit_idx_n = BIT_LAST;
          state_n   = TX_START;
        end
      end
      TX_START, TX_DATA, TX_GUARD: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          phase_n = ~phase;
          if (phase) begin
            if (state == TX_START) begin
              state_n = TX_DATA;
            end else if (state == TX_DATA) begin
              shreg_n = shreg << 1;
              if (bit_idx == '0) begin
                state_n = TX_GUARD;
              end else begin
                bit_idx_n = bit_idx - BIT_W'(1);
              end
            end else begin
              state_n = TX_IDLE;
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = TX_IDLE;
      end
    endcase

    start_h = man_halves(START_BIT, POLARITY);
    data_h  = man_halves(shreg_n[DATA_W-1], POLARITY);
    case (state_n)
      TX_START: line_n = phase_n ? start_h[0] : start_h[1];
      TX_DATA:  line_n = phase_n ? data_h[0] : data_h[1];
      default:  line_n = 1'b0;
    endcase
  end

  assign tx_ready = (state == TX_IDLE);
  assign tx_out   = line;

  // The loopback path takes the already-registered TX line directly, so it
  // skips the synchroniser latency of the external input.
  assign dec_in = loopback ? line : rx_sync;

  manchester_rx #(
    .DATA_W   (DATA_W),
    .HALF_CYC (HALF_CYC),
    .POLARITY (POLARITY)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .rx_sync  (rx_sync),
    .dec_in   (dec_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

endmodule

// File: tb/tb_manchester_codec.sv
// Self-checking bench for manchester_codec.
// dut0 uses IEEE polarity, dut1 uses Thomas polarity with loopback tied on.
// Stimulus pushes expected decoder events into per-DUT queues and monitors
// pop and compare them whenever a DUT strobes rx_valid or rx_err.
module tb_manchester_codec;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;
  logic       tx_ready0, tx_ready1;
  logic       tx_out0, tx_out1;
  logic       rx_in0, rx_in1;
  logic       loopback0, loopback1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       rx_err0, rx_err1;

  exp_t exp0[$];
  exp_t exp1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  manchester_codec #(.DATA_W(8), .HALF_CYC(4), .POLARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_out(tx_out0), .rx_in(rx_in0), .loopback(loopback0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_err(rx_err0)
  );

  manchester_codec #(.DATA_W(8), .HALF_CYC(4), .POLARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_out(tx_out1), .rx_in(rx_in1), .loopback(loopback1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_err(rx_err1)
  );

  // Free-running clock and a cycle number that holds the index of the
  // current cycle from just after each rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic popAndCompare(input int sel, input logic is_err, input logic [7:0] d);
    exp_t e;
    int   n;
    n = (sel == 0) ? exp0.size() : exp1.size();
    if (n == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL dut%0d_unexpected_rx: got err=%0b data=0x%02h at cycle %0d, required no event",
               sel, is_err, d, cyc);
    end else begin
      if (sel == 0) e = exp0.pop_front();
      else          e = exp1.pop_front();
      checkOutput($sformatf("dut%0d_rx_kind", sel), {31'd0, is_err}, {31'd0, e.is_err});
      if (!is_err) checkOutput($sformatf("dut%0d_rx_data", sel), {24'd0, d}, {24'd0, e.data});
      checkOutput($sformatf("dut%0d_rx_cycle", sel), cyc, e.cyc);
    end
  endtask

  // Monitors: sample decoder strobes on the falling edge, away from the
  // edge where the DUT updates them.
  always @(negedge clk) begin
    if (rx_valid0) popAndCompare(0, 1'b0, rx_data0);
    if (rx_err0)   popAndCompare(0, 1'b1, rx_data0);
  end

  always @(negedge clk) begin
    if (rx_valid1) popAndCompare(1, 1'b0, rx_data1);
    if (rx_err1)   popAndCompare(1, 1'b1, rx_data1);
  end

  // Offers a word on one DUT and returns the acceptance cycle. Entered and
  // left one time unit after a rising edge; returns on the cycle after
  // acceptance. When expect_rx is set the loopback decode is scheduled
  // 72 cycles after acceptance: 1 + 17*4 + 2 + 1.
  task automatic applyStimulus(input int sel, input logic [7:0] word, input bit expect_rx, output int acc);
    int waited;
    bit done;
    logic rdy;
    waited = 0;
    done = 0;
    acc = -1;
    if (sel == 0) begin tx_data0 = word; tx_valid0 = 1'b1; end
    else          begin tx_data1 = word; tx_valid1 = 1'b1; end
    while (!done && waited < 200) begin
      rdy = (sel == 0) ? tx_ready0 : tx_ready1;
      if (rdy === 1'b1) begin
        acc = cyc;
        done = 1;
      end
      @(posedge clk); #1;
      waited++;
    end
    if (sel == 0) tx_valid0 = 1'b0;
    else          tx_valid1 = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL dut%0d_accept_timeout: got no tx_ready in 200 cycles, required acceptance", sel);
    end else if (expect_rx) begin
      if (sel == 0) exp0.push_back('{1'b0, word, acc + 72});
      else          exp1.push_back('{1'b0, word, acc + 72});
    end
  endtask

  // Walks the 20 half-bits of a frame right after acceptance, checking the
  // line level on every cycle of each half and counting busy cycles.
  task automatic checkLine(input int sel, input logic [19:0] halves, input string tag);
    int busy;
    logic expb;
    logic ok;
    logic ln, rdy;
    busy = 0;
    for (int h = 0; h < 20; h++) begin
      expb = halves[19 - h];
      ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
        ln  = (sel == 0) ? tx_out0 : tx_out1;
        rdy = (sel == 0) ? tx_ready0 : tx_ready1;
        if (ln !== expb) ok = 1'b0;
        if (rdy === 1'b0) busy++;
        @(posedge clk); #1;
      end
      checkOutput($sformatf("%s_half%0d_ok", tag, h), {31'd0, ok}, 32'd1);
    end
    rdy = (sel == 0) ? tx_ready0 : tx_ready1;
    checkOutput({tag, "_busy_cycles"}, busy, 80);
    checkOutput({tag, "_ready_back"}, {31'd0, rdy}, 32'd1);
  endtask

  // Drives the first n entries of pat (MSB first) onto rx_in0, one per half-bit.
  task automatic driveRx(input logic [19:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in0 = pat[n - 1 - i];
      repeat (4) begin @(posedge clk); #1; end
    end
    rx_in0 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput({tag, "_pending"}, exp0.size() + exp1.size(), 0);
  endtask

  // Main directed sequence.
  initial begin
    int   acc, acc2, m, stray;
    logic [19:0] pat;

    rst_n = 1'b0;
    tx_data0 = 8'h00; tx_valid0 = 1'b0; rx_in0 = 1'b0; loopback0 = 1'b0;
    tx_data1 = 8'h00; tx_valid1 = 1'b0; rx_in1 = 1'b0; loopback1 = 1'b1;

    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("reset_tx_ready", {31'd0, tx_ready0}, 32'd1);
    checkOutput("reset_tx_out", {31'd0, tx_out0}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, rx_data0}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid0}, 32'd0);
    checkOutput("reset_rx_err", {31'd0, rx_err0}, 32'd0);
    stray = 0;
    repeat (20) begin
      if (tx_ready0 !== 1'b1 || tx_out0 !== 1'b0 || rx_valid0 !== 1'b0 || rx_err0 !== 1'b0 ||
          rx_data0 !== 8'h00 || tx_ready1 !== 1'b1 || tx_out1 !== 1'b0)
        stray++;
      @(posedge clk); #1;
    end
    checkOutput("reset_idle_stable", stray, 0);

    // 0xA5, IEEE: start 10, then 1,0,1,0,0,1,0,1 and guard 00.
    applyStimulus(0, 8'hA5, 1'b0, acc);
    checkLine(0, 20'b10_01_10_01_10_10_01_10_01_00, "enc_a5");

    loopback0 = 1'b1;
    applyStimulus(0, 8'hA5, 1'b1, acc);
    applyStimulus(0, 8'h3C, 1'b1, acc2);
    checkOutput("b2b_accept_gap", acc2 - acc, 81);
    drain("loopback_b2b");

    // Start 10, data bit 1 as 01, then 11 which is a violation. The error
    // lands 25 cycles after the first drive: 2 sync + 2 + 5*4 + 1.
    loopback0 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    m = cyc;
    exp0.push_back('{1'b1, 8'h00, m + 25});
    pat = 20'b10_01_11;
    driveRx(pat, 6);
    repeat (40) begin @(posedge clk); #1; end
    checkOutput("viol_pending", exp0.size(), 0);
    checkOutput("viol_rx_data_held", {24'd0, rx_data0}, 32'h3C);

    // Clean 0x0F on the external line: decode 73 cycles after first drive.
    m = cyc;
    exp0.push_back('{1'b0, 8'h0F, m + 73});
    pat = 20'b10_10_10_10_10_01_01_01_01;
    driveRx(pat, 18);
    drain("ext_0f");

    // Reset during the high second half of data bit 3 of 0xFF.
    loopback0 = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    applyStimulus(0, 8'hFF, 1'b0, acc);
    repeat (37) begin @(posedge clk); #1; end
    checkOutput("pre_reset_line", {31'd0, tx_out0}, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_line", {31'd0, tx_out0}, 32'd0);
    checkOutput("reset_async_ready", {31'd0, tx_ready0}, 32'd1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("post_reset_ready", {31'd0, tx_ready0}, 32'd1);
    checkOutput("post_reset_rx_data", {24'd0, rx_data0}, 32'd0);
    applyStimulus(0, 8'h81, 1'b1, acc);
    drain("after_reset_81");

    // Thomas polarity: 0 encodes low,high; start still high,low.
    applyStimulus(1, 8'h00, 1'b1, acc);
    checkLine(1, 20'b10_01_01_01_01_01_01_01_01_00, "pol1_00");
    drain("pol1_loop");

    repeat (10) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/manchester_codec.md
# manchester_codec

Parametrised Manchester encoder/decoder, successor to the fixed 8-bit encoder in the Tiny Tapeout top level. It serialises `DATA_W`-bit words with a valid/ready handshake into a framed Manchester line, and recovers framed words from an incoming line with code-violation detection. A loopback mode lets the top level self-test without external wiring. It sits directly behind the `tt_um_*` pin mapping: `tx_out` drives a `uo_out` bit and `rx_in` comes from a `ui_in` bit.

## Interface
- `DATA_W`, default 8: word width, ≥1.
- `HALF_CYC`, default 4: clock cycles per half-bit, even, ≥2.
- `POLARITY`, default 0: 0 = IEEE 802.3 (bit 0 → high,low; bit 1 → low,high); 1 = G.E. Thomas (inverted).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_W: word to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: encoder can accept a word.
- `tx_out` out 1: registered Manchester line; idles low.
- `rx_in` in 1: asynchronous Manchester line.
- `loopback` in 1: 1 = decoder input is `tx_out` (bypasses synchroniser); 0 = `rx_in`.
- `rx_data` out DATA_W: last decoded word; holds until the next `rx_valid`.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `rx_err` out 1: one-cycle pulse on a code violation.

## Operation
- Reset values: `tx_out`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `rx_err`=0. Both FSMs go to IDLE.
- Frame layout: start bit, then `DATA_W` data bits MSB first, then a guard of 2 half-bits low.
  - The start bit is always encoded (high, low), whatever the polarity. It is the logical value that `POLARITY` maps to high-first.
  - Data bit halves follow `POLARITY`.
- TX FSM states: IDLE, START, DATA, GUARD.
  - IDLE: `tx_ready`=1, `tx_out`=0. When `tx_valid && tx_ready`, latch `tx_data` into a shift register and go to START.
  - START: 2 half-bits, then DATA.
  - DATA: 2·`DATA_W` half-bits. Shift on each bit boundary; the bit index decrements and wraps to terminal at 0. Then GUARD.
  - GUARD: 2 half-bits low, then IDLE.
  - `tx_ready`=0 in every non-IDLE state. `tx_valid` is ignored while busy. Words are never dropped, because they are never accepted.
  - A half-bit counter runs 0..HALF_CYC−1.
- RX path:
  - `rx_in` passes through a 2-flop synchroniser.
  - The decoder input is the synchroniser output, or `tx_out` when `loopback`=1.
- RX FSM states: IDLE, START, DATA.
  - IDLE: a rising edge on the decoder input (0 → 1) marks cycle E and the FSM goes to START.
  - Sample point k (k = 0..2·`DATA_W`+1) is at E + `HALF_CYC`/2 + k·`HALF_CYC`.
  - START: samples 0 and 1 must be (1,0). Otherwise pulse `rx_err` and return to IDLE.
  - DATA: each sample pair (a,b) must have a≠b. The bit value is decoded by `POLARITY` and shifted in MSB first.
  - a==b → `rx_err` pulse, word discarded, return to IDLE. `rx_data` is unchanged.
  - After the final sample: `rx_data` ← shift register and `rx_valid` pulses the next cycle. Return to IDLE, which re-arms edge detection.
- Simultaneous events:
  - TX and RX are independent.
  - `loopback` changes take effect immediately. Mid-frame changes are undefined and are not verified.
- Reset mid-operation: everything returns to reset values asynchronously, and `tx_out` drops to 0 with no glitch high.

## Timing
- Accept on cycle N: `tx_out` is high from N+1.
- Each half-bit lasts exactly `HALF_CYC` cycles.
- `tx_ready` re-asserts on cycle N+1+(2·`DATA_W`+4)·`HALF_CYC`. A word accepted on that cycle starts the next frame.
- Loopback decode latency: `rx_valid` on cycle N+1+(2·`DATA_W`+1)·`HALF_CYC`+`HALF_CYC`/2+1. External `rx_in` adds 2 cycles for the synchroniser.
- `rx_err` is asserted the cycle after the offending sample.

## Structure
- Package `manchester_pkg`:
  - TX and RX state enums.
  - Polarity localparams `POL_IEEE`=0 and `POL_THOMAS`=1.
  - Function `man_halves(bit, pol)` returning the 2-bit half pattern.
- Sub-module `manchester_rx` (synchroniser, edge detector, RX FSM, sampler).
- The TX FSM, the loopback mux and the counter width `$clog2(HALF_CYC)` stay in `manchester_codec`.

## Test plan
Defaults unless stated: `DATA_W`=8, `HALF_CYC`=4.
- **Reset:** hold `rst_n`=0 for 5 cycles, release → all outputs at reset values, `tx_ready`=1, `tx_out`=0 for 20 idle cycles.
- **Encode, `POLARITY`=0:** send 0xA5 → half-bit sequence 10, 01,10,01,10,10,01,10,01, 00. `tx_ready` low for exactly 80 cycles.
- **Loopback back-to-back:** `loopback`=1, send 0xA5 then 0x3C (second `tx_valid` held high) → two `rx_valid` pulses with 0xA5 and 0x3C at the computed latency, `rx_err` never set.
- **Violation:** drive `rx_in` with start 10, then halves 01,11 → one `rx_err` pulse, no `rx_valid`, `rx_data` unchanged. A following clean 0x0F frame decodes correctly.
- **Reset mid-frame:** assert `rst_n` low during data bit 3 of 0xFF → `tx_out`=0 immediately, no `rx_valid`. After release, `tx_ready`=1 and a 0x81 frame round-trips in loopback.
- **`POLARITY`=1:** send 0x00 → data halves all 01, start stays 10. The loopback round-trip yields 0x00.
